imem_prefetch_buffer: RTL and testbench

- Sits between the instruction memory and the fetch stage of the pipelined 16-bit RISC datapath.
- Prefetches sequential halfword instructions over a req/ack memory handshake that may take multiple cycles, and queues them in a small FIFO of {address, instruction} pairs.
- Presents the instruction matching the datapath's current PC (instrAddrF) together with a valid flag.
- Flushes and restarts on any PC redirect (branch, jump, JR, reset), and discards stale in-flight responses.

---
 rtl/imem_prefetch_buffer.sv | 163 ++++++++++++++++
 tb/tb_imem_prefetch_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_prefetch_buffer.sv
// Instruction prefetch buffer between instruction memory and the fetch stage.
// Sequential halfword addresses are requested over a req/ack handshake, and the
// returned {address, instruction} pairs are queued in a small FIFO. The head entry
// is presented when its address matches the datapath PC. Any PC that differs from
// the address the buffer expects flushes the queue and restarts prefetch there.
// A response that is still in flight when the flush happens is drained and dropped.
//
// state | meaning
// IDLE  | no request outstanding; issue the next one if the FIFO has room
// WAIT  | request outstanding; its response will be queued
// DROP  | request outstanding; its response is stale and will be discarded

module imem_prefetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fetch_addr,
    input  logic        fetch_en,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    fifo_addr_q [DEPTH];
    logic [15:0]    fifo_addr_d [DEPTH];
    logic [15:0]    fifo_data_q [DEPTH];
    logic [15:0]    fifo_data_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [15:0]    pf_addr_q, pf_addr_d;
    logic           mem_req_q, mem_req_d;
    logic [15:0]    mem_addr_q, mem_addr_d;

    logic [15:0]    head_addr;
    logic [15:0]    head_data;
    logic [15:0]    expected_addr;
    logic           not_empty;
    logic           redirect;
    logic           push;
    logic           pop;

    // Head of queue, the address the buffer expects next, and the handshake decisions.
    always_comb begin
        head_addr = fifo_addr_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
        not_empty = (count_q != '0);
        if (not_empty) begin
            expected_addr = head_addr;
        end else if (state_q == WAIT) begin
            expected_addr = mem_addr_q;
        end else begin
            expected_addr = pf_addr_q;
        end
        redirect    = (fetch_addr != expected_addr);
        instr_valid = not_empty && (head_addr == fetch_addr);
        instr       = instr_valid ? head_data : 16'h0000;
        pop         = instr_valid && fetch_en && !redirect;
        push        = (state_q == WAIT) && mem_ack && !redirect;
    end

    // Next-state computation for the queue, prefetch address and request FSM.
    always_comb begin
        state_d     = state_q;
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pf_addr_d   = pf_addr_q;
        mem_addr_d  = mem_addr_q;

        if (redirect) begin
            // Flush; the outstanding request (if any) can no longer be used.
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            pf_addr_d = fetch_addr;
            case (state_q)
                WAIT:    state_d = mem_ack ? IDLE : DROP;
                DROP:    state_d = mem_ack ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            if (push) begin
                fifo_addr_d[wr_ptr_q] = mem_addr_q;
                fifo_data_d[wr_ptr_q] = mem_rdata;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            case (state_q)
                IDLE: begin
                    // Room is judged on the current occupancy so a full queue never overflows.
                    if (count_q < FULL_COUNT) begin
                        mem_addr_d = pf_addr_q;
                        pf_addr_d  = pf_addr_q + 16'd2;
                        state_d    = WAIT;
                    end
                end
                WAIT:    if (mem_ack) state_d = IDLE;
                DROP:    if (mem_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        mem_req_d = (state_d != IDLE);
    end

    // State registers, queue storage and registered memory interface outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pf_addr_q  <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_q[i] <= 16'h0000;
                fifo_data_q[i] <= 16'h0000;
            end
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pf_addr_q   <= pf_addr_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            fifo_addr_q <= fifo_addr_d;
            fifo_data_q <= fifo_data_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// Self-checking bench for imem_prefetch_buffer: a vector table for the steady
// fetch stream, then hand-written sequences for fill, flush, drop, wrap and reset.

module tb_imem_prefetch_buffer;

    logic        clk;
    logic        reset;
    logic [15:0] fetch_addr;
    logic        fetch_en;
    logic [15:0] instr;
    logic        instr_valid;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    imem_prefetch_buffer #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_addr  (fetch_addr),
        .fetch_en    (fetch_en),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] fa;
        logic        en;
        logic        ack;
        logic [15:0] rdata;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic        exp_req;
        logic [15:0] exp_addr;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        s_valid;
    logic [15:0] s_instr;
    logic        s_req;
    logic [15:0] s_addr;
    logic [15:0] req_log [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs, let combinational outputs settle, sample.
    task automatic drive(input logic [15:0] fa, input logic en, input logic ack, input logic [15:0] rd);
        fetch_addr = fa;
        fetch_en   = en;
        mem_ack    = ack;
        mem_rdata  = rd;
        #1;
        s_valid = instr_valid;
        s_instr = instr;
        s_req   = mem_req;
        s_addr  = mem_addr;
    endtask

    // mode 0: no ack, 1: memory acks any request (data = addr+0x1000), 2: ack forced with junk data.
    task automatic step(input logic [15:0] fa, input logic en, input int mode);
        logic        ack;
        logic [15:0] rd;
        ack = (mode == 1) ? mem_req : (mode == 2);
        rd  = (mode == 2) ? 16'hBEEF : mem_addr + 16'h1000;
        drive(fa, en, ack, rd);
        if (s_req && ack) req_log.push_back(s_addr);
        if (s_valid) check("data_integrity", s_instr, fa + 16'h1000);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        fetch_addr = 16'h0000;
        fetch_en   = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {15'd0, mem_req}, 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_valid", {15'd0, instr_valid}, 16'd0);
        check("rst_instr", instr, 16'h0000);
        reset = 1'b0;
        req_log.delete();
    endtask

    initial begin
        logic [15:0] pc;
        int          lat;
        bit          found;

        vecs[0]  = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vecs[2]  = '{16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1000, 1'b0, 16'h0000};
        vecs[3]  = '{16'h0002, 1'b1, 1'b1, 16'h1002, 1'b0, 16'h0000, 1'b1, 16'h0002};
        vecs[4]  = '{16'h0002, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1002, 1'b0, 16'h0002};
        vecs[5]  = '{16'h0004, 1'b1, 1'b1, 16'h1004, 1'b0, 16'h0000, 1'b1, 16'h0004};
        vecs[6]  = '{16'h0004, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1004, 1'b0, 16'h0004};
        vecs[7]  = '{16'h0006, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0006};
        vecs[8]  = '{16'h0006, 1'b1, 1'b1, 16'h1006, 1'b0, 16'h0000, 1'b1, 16'h0006};
        vecs[9]  = '{16'h0006, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1006, 1'b0, 16'h0006};
        vecs[10] = '{16'h0006, 1'b1, 1'b1, 16'h1008, 1'b1, 16'h1006, 1'b1, 16'h0008};
        vecs[11] = '{16'h0008, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1008, 1'b0, 16'h0008};
        vecs[12] = '{16'h000A, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000A};

        // Sequential stream after reset, including a delayed ack and same-cycle push/pop.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].fa, vecs[i].en, vecs[i].ack, vecs[i].rdata);
            check($sformatf("v%0d_valid", i), {15'd0, s_valid}, {15'd0, vecs[i].exp_valid});
            check($sformatf("v%0d_instr", i), s_instr, vecs[i].exp_instr);
            check($sformatf("v%0d_req", i), {15'd0, s_req}, {15'd0, vecs[i].exp_req});
            check($sformatf("v%0d_addr", i), s_addr, vecs[i].exp_addr);
            @(negedge clk);
        end

        // Fill with fetch stalled, then drain one per cycle; prefetch resumes at 0008.
        do_reset();
        for (int i = 0; i < 12; i++) step(16'h0000, 1'b0, 1);
        check("fill_req_idle", {15'd0, s_req}, 16'd0);
        check("fill_num_req", 16'(req_log.size()), 16'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            check($sformatf("fill_req%0d", i), req_log[i], 16'(2 * i));
        pc = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            step(pc, 1'b1, 1);
            check($sformatf("drain_valid%0d", i), {15'd0, s_valid}, 16'd1);
            if (s_valid) pc = pc + 16'd2;
        end
        check("resume_seen", {15'd0, (req_log.size() >= 5)}, 16'd1);
        if (req_log.size() >= 5) check("resume_addr", req_log[4], 16'h0008);

        // Full FIFO flushed by a redirect to 0040; old entries never reappear.
        do_reset();
        for (int i = 0; i < 12; i++) step(16'h0000, 1'b0, 1);
        check("full_head_instr", s_instr, 16'h1000);
        step(16'h0040, 1'b1, 1);
        check("flush_valid", {15'd0, s_valid}, 16'd0);
        req_log.delete();
        lat   = 0;
        found = 0;
        for (int k = 1; k <= 8 && !found; k++) begin
            step(16'h0040, 1'b1, 1);
            if (s_valid) begin
                found = 1;
                lat   = k;
            end
        end
        check("flush_latency", 16'(lat), 16'd3);
        check("flush_first_req", (req_log.size() > 0) ? req_log[0] : 16'hFFFF, 16'h0040);

        // Redirect while waiting on a slow ack for 0008: response dropped, next request 0100.
        do_reset();
        pc    = 16'h0000;
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (mem_req && mem_addr == 16'h0008) begin
                found = 1;
            end else begin
                step(pc, 1'b1, 1);
                if (s_valid) pc = pc + 16'd2;
            end
        end
        check("drop_reached_0008", {15'd0, found}, 16'd1);
        step(16'h0008, 1'b1, 0);
        step(16'h0100, 1'b1, 0);
        step(16'h0100, 1'b1, 0);
        check("drop_hold_req", {15'd0, s_req}, 16'd1);
        check("drop_hold_addr", s_addr, 16'h0008);
        step(16'h0100, 1'b1, 1);
        check("drop_ack_valid", {15'd0, s_valid}, 16'd0);
        step(16'h0100, 1'b1, 0);
        check("drop_idle_valid", {15'd0, s_valid}, 16'd0);
        step(16'h0100, 1'b1, 1);
        check("drop_next_req", {15'd0, s_req}, 16'd1);
        check("drop_next_addr", s_addr, 16'h0100);
        step(16'h0100, 1'b1, 1);
        check("drop_new_valid", {15'd0, s_valid}, 16'd1);
        check("drop_new_instr", s_instr, 16'h1100);

        // Prefetch address wraps from FFFE to 0000.
        do_reset();
        step(16'hFFFE, 1'b1, 1);
        step(16'hFFFE, 1'b1, 1);
        step(16'hFFFE, 1'b1, 1);
        check("wrap_req_fffe", s_addr, 16'hFFFE);
        step(16'hFFFE, 1'b1, 1);
        check("wrap_valid_fffe", {15'd0, s_valid}, 16'd1);
        step(16'h0000, 1'b1, 1);
        check("wrap_req", {15'd0, s_req}, 16'd1);
        check("wrap_addr", s_addr, 16'h0000);
        step(16'h0000, 1'b1, 1);
        check("wrap_instr", s_instr, 16'h1000);

        // Async reset in the middle of a WAIT; an ack just after release is ignored.
        do_reset();
        step(16'h0200, 1'b0, 0);
        step(16'h0200, 1'b0, 0);
        step(16'h0200, 1'b0, 0);
        check("midrst_pre_addr", s_addr, 16'h0200);
        #2 reset = 1'b1;
        #1;
        check("midrst_req", {15'd0, mem_req}, 16'd0);
        check("midrst_addr", mem_addr, 16'h0000);
        check("midrst_valid", {15'd0, instr_valid}, 16'd0);
        check("midrst_instr", instr, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step(16'h0000, 1'b1, 2);
        check("postrst_req", {15'd0, s_req}, 16'd0);
        step(16'h0000, 1'b1, 0);
        check("postrst_first_req", {15'd0, s_req}, 16'd1);
        check("postrst_first_addr", s_addr, 16'h0000);
        check("postrst_no_stale", {15'd0, s_valid}, 16'd0);
        step(16'h0000, 1'b1, 1);
        step(16'h0000, 1'b1, 1);
        check("postrst_valid", {15'd0, s_valid}, 16'd1);
        check("postrst_instr", s_instr, 16'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
